vga_mem_arbiter: RTL
====================

Name: vga_mem_arbiter

Overview:
Arbitrates a single-port synchronous image RAM between two requesters: the VGA pixel fetch path (real-time, high priority) and the ASIP load/store port (stallable). The VGA path keeps highest priority. A starvation guard grants the ASIP one slot after a bounded wait and reports the dropped pixel fetch. It sits between the processor core, the VGA controller and the frame memory inside rsa_asip_system.

Parameters:
AW, 19, word address width (covers 640x480 = 307200 pixels)
DW, 8, data width (one 8-bit pixel per word)
STARVE_LIMIT, 64, consecutive denied ASIP cycles before a forced ASIP grant (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
vga_req  in  1  pixel fetch request; single-cycle, may be asserted every cycle
vga_addr  in  AW  pixel fetch address
vga_valid  out  1  pixel data valid pulse
vga_rdata  out  DW  fetched pixel; holds last value otherwise
vga_miss  out  1  pulse: a VGA request was dropped for a forced ASIP grant
cpu_req  in  1  ASIP access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  ASIP address
cpu_wdata  in  DW  ASIP write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid with cpu_ack; holds value
miss_count  out  16  saturating count of vga_miss pulses
mem_addr  out  AW  RAM address (combinational mux)
mem_we  out  1  RAM write enable (combinational)
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid one cycle after the address

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs 0, ASIP FSM to IDLE, starvation counter 0, VGA pipeline flushed. A read in flight is discarded with no ack. mem_we must be 0 during reset.
- Grant in cycle N, combinational:
  - force = cpu_pending & (starve_cnt == STARVE_LIMIT).
  - cpu_pending = cpu_req & FSM==IDLE.
  - If vga_req & !force: VGA owns the port.
  - Else if cpu_pending: ASIP owns the port.
  - Else: port idle, mem_we=0, mem_addr=0.
- VGA latency:
  - Grant at N -> vga_valid=1 in N+2, with vga_rdata = mem_rdata sampled at end of N+1.
  - Fully pipelined, one result per cycle.
- ASIP FSM states: IDLE, RD_WAIT, ACK.
  - Write granted at N: RAM written at N; ACK in N+1 (cpu_ack=1); then IDLE.
  - Read granted at N: RD_WAIT in N+1 captures mem_rdata; ACK in N+2 with cpu_rdata; then IDLE.
  - cpu_req is ignored in RD_WAIT and ACK, so a held request is never granted twice.
  - The next request can be granted in the cycle after ACK.
- Starvation counter:
  - Increments each cycle with cpu_pending & vga_req & !force, saturating at STARVE_LIMIT.
  - Clears to 0 on any ASIP grant.
- Forced grant:
  - The VGA request in that cycle is dropped: no vga_valid for it, vga_rdata holds its previous value.
  - vga_miss pulses in N+2, aligned to where vga_valid would have been.
  - miss_count increments and saturates at 0xFFFF.
- Simultaneous vga_req and cpu_req with counter below the limit: VGA wins and the counter increments.
- A change of cpu_addr/cpu_we while cpu_req is held is a protocol violation and the behaviour is unspecified.

Test Plan:
- Reset: hold rst=0 with vga_req=cpu_req=1 -> all outputs 0, mem_we=0. Release rst -> normal arbitration from the first edge.
- VGA stream: vga_req every cycle, addr 0..9, RAM preloaded with data = addr+0x10 -> vga_valid 10 consecutive cycles, starting 2 cycles after the first request. Data 0x10..0x19 in order.
- ASIP write then read, VGA idle: write 0xA5 to addr 0x00123 -> cpu_ack 1 cycle after grant. Read the same address -> cpu_ack 2 cycles after grant, cpu_rdata=0xA5, exactly one ack each.
- Contention: vga_req continuous, cpu read pending, STARVE_LIMIT=4:
  - ASIP is granted on the 5th pending cycle.
  - One vga_miss pulse appears and that pixel has no vga_valid.
  - miss_count=1, counter returns to 0.
- Idle gaps: vga_req every other cycle with cpu_req held -> ASIP is served in the gaps and vga_miss never asserts.
- Reset mid-read: assert rst in RD_WAIT -> no cpu_ack. After release, a fresh request completes normally.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port frame RAM arbiter between the VGA pixel fetch path and the ASIP load/store port.
// VGA has priority. After STARVE_LIMIT denied cycles the ASIP takes one forced slot, and the
// dropped pixel fetch is reported on vga_miss.
module vga_mem_arbiter #(
  parameter int unsigned AW           = 19,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [15:0]   miss_count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StAck    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          vga_p1_q, vga_valid_q;
  logic          miss_p1_q, vga_miss_q;
  logic [DW-1:0] vga_rdata_q, cpu_rdata_q;
  logic [15:0]   miss_count_q;

  logic cpu_pending, force_grant, vga_grant, cpu_grant;

  // Grant decision for the current cycle; VGA wins unless the starvation guard fires.
  always_comb begin
    cpu_pending = cpu_req & (state_q == StIdle);
    force_grant = cpu_pending & (starve_q == CW'(STARVE_LIMIT));
    vga_grant   = vga_req & ~force_grant;
    cpu_grant   = cpu_pending & ~vga_grant;
  end

  // RAM port mux; held quiet while reset is asserted so no stray write can reach the RAM.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst) begin
      if (vga_grant) begin
        mem_addr = vga_addr;
      end else if (cpu_grant) begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
        if (cpu_we) mem_wdata = cpu_wdata;
      end
    end
  end

  // Starvation counter: counts denied ASIP cycles, clears on any ASIP grant.
  always_comb begin
    starve_d = starve_q;
    if (cpu_grant) begin
      starve_d = '0;
    end else if (cpu_pending && vga_req && (starve_q != CW'(STARVE_LIMIT))) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // ASIP FSM next state; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (cpu_grant) state_d = cpu_we ? StAck : StRdWait;
      StRdWait: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, VGA read pipeline, miss reporting and read-data capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      starve_q     <= '0;
      vga_p1_q     <= 1'b0;
      vga_valid_q  <= 1'b0;
      miss_p1_q    <= 1'b0;
      vga_miss_q   <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      vga_p1_q    <= vga_grant;
      vga_valid_q <= vga_p1_q;
      // A forced grant with a live VGA request drops that pixel.
      miss_p1_q   <= force_grant & vga_req;
      vga_miss_q  <= miss_p1_q;
      if (vga_p1_q) vga_rdata_q <= mem_rdata;
      if (state_q == StRdWait) cpu_rdata_q <= mem_rdata;
      if (miss_p1_q && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign vga_valid  = vga_valid_q;
  assign vga_rdata  = vga_rdata_q;
  assign vga_miss   = vga_miss_q;
  assign cpu_ack    = (state_q == StAck);
  assign cpu_rdata  = cpu_rdata_q;
  assign miss_count = miss_count_q;

endmodule
